mem_access: RTL

MEM_ACCESS -- requirements
Module: mem_access

---
 rtl/mem_access_if.sv | 20 ++
 rtl/mem_access.sv | 120 ++++++++++++
 2 files changed

// File: rtl/mem_access_if.sv
// Memory-side request/acknowledge bus of the MEM stage.
// A request is held stable until the memory returns Data_ack.
interface mem_access_if;
    logic        Data_req;
    logic        Data_rd;
    logic [15:0] Data_addr;
    logic [15:0] Data_din;
    logic [15:0] Data_dout;
    logic        Data_ack;

    modport master (
        output Data_req, Data_rd, Data_addr, Data_din,
        input  Data_dout, Data_ack
    );

    modport slave (
        input  Data_req, Data_rd, Data_addr, Data_din,
        output Data_dout, Data_ack
    );
endinterface

// File: rtl/mem_access.sv
// MEM pipeline stage: runs LD/LDR/LDI/ST/STR/STI against a req/ack memory; done 2 edges after start (3 if indirect) plus waits.
// Backpressure: busy stalls the controller; a start while busy is dropped; the request holds until Data_ack.
module mem_access (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] IR_Exec,
    input  logic [15:0] addr_in,
    input  logic [15:0] M_Data,
    mem_access_if.master bus,
    output logic [15:0] memout,
    output logic        mem_valid,
    output logic        done,
    output logic        busy,
    output logic [15:0] IR_Mem
);
    localparam logic [3:0] OP_LD  = 4'b0010;
    localparam logic [3:0] OP_LDR = 4'b0110;
    localparam logic [3:0] OP_LDI = 4'b1010;
    localparam logic [3:0] OP_ST  = 4'b0011;
    localparam logic [3:0] OP_STR = 4'b0111;
    localparam logic [3:0] OP_STI = 4'b1011;

    typedef enum logic [1:0] {IDLE, READ, INDIRECT, WRITE} state_t;

    state_t      state_q, state_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] data_q, data_d;
    logic [15:0] ir_d;
    logic [15:0] memout_d;
    logic        req_q, req_d;
    logic        valid_d, done_d;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Data_req rises one edge after entering a bus state; ack is only honoured once it is up.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        data_d   = data_q;
        ir_d     = IR_Mem;
        memout_d = memout;
        req_d    = req_q;
        valid_d  = 1'b0;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                req_d = 1'b0;
                if (start) begin
                    case (IR_Exec[15:12])
                        OP_LD, OP_LDR:  state_d = READ;
                        OP_LDI, OP_STI: state_d = INDIRECT;
                        OP_ST, OP_STR:  state_d = WRITE;
                        default:        state_d = IDLE;
                    endcase
                    if (state_d != IDLE) begin
                        addr_d = addr_in;
                        data_d = M_Data;
                        ir_d   = IR_Exec;
                    end
                end
            end
            READ: begin
                req_d = 1'b1;
                if (req_q && bus.Data_ack) begin
                    memout_d = bus.Data_dout;
                    valid_d  = 1'b1;
                    done_d   = 1'b1;
                    req_d    = 1'b0;
                    state_d  = IDLE;
                end
            end
            INDIRECT: begin
                req_d = 1'b1;
                if (req_q && bus.Data_ack) begin
                    addr_d  = bus.Data_dout;
                    state_d = (IR_Mem[15:12] == OP_LDI) ? READ : WRITE;
                end
            end
            WRITE: begin
                req_d = 1'b1;
                if (req_q && bus.Data_ack) begin
                    done_d  = 1'b1;
                    req_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            addr_q    <= 16'h0;
            data_q    <= 16'h0;
            IR_Mem    <= 16'h0;
            memout    <= 16'h0;
            req_q     <= 1'b0;
            mem_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            addr_q    <= addr_d;
            data_q    <= data_d;
            IR_Mem    <= ir_d;
            memout    <= memout_d;
            req_q     <= req_d;
            mem_valid <= valid_d;
            done      <= done_d;
        end
    end

    assign bus.Data_req  = req_q;
    assign bus.Data_rd   = (state_q == READ) || (state_q == INDIRECT);
    assign bus.Data_addr = (state_q != IDLE) ? addr_q : 16'h0;
    assign bus.Data_din  = (state_q == WRITE) ? data_q : 16'h0;
    assign busy          = (state_q != IDLE);
endmodule
